// File: rtl/sdft_bin_mag.sv
// sdft_bin_mag: after each SDFT update, scans the first scan_bins bins through a
// synchronous read port and streams scaled, saturated re^2+im^2 per bin with
// bin index and last flag on a valid/ready interface.
module sdft_bin_mag #(
  parameter int data_width = 8,
  parameter int freq_bins  = 16,
  parameter int scan_bins  = 8,
  parameter int mag_shift  = 8,
  parameter int out_width  = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sdft_ready,
  output logic                           busy,
  output logic [$clog2(freq_bins)-1:0]   bin_addr,
  input  logic signed [2*data_width-1:0] bin_real,
  input  logic signed [2*data_width-1:0] bin_imag,
  output logic [out_width-1:0]           mag_data,
  output logic [$clog2(freq_bins)-1:0]   mag_bin,
  output logic                           mag_last,
  output logic                           mag_valid,
  input  logic                           mag_ready,
  output logic                           overrun
);

  localparam int AW = $clog2(freq_bins);
  localparam int CW = 2 * data_width;
  localparam int SW = 4 * data_width + 1;
  localparam int EW = (SW > out_width) ? SW : out_width;
  localparam logic [AW-1:0] LAST_BIN = AW'(scan_bins - 1);

  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, EMIT} state_t;

  state_t state, state_nxt;

  logic                 sdft_ready_d;
  logic                 trigger;
  logic                 accept;
  logic signed [CW-1:0] re_q, im_q;
  logic signed [2*CW-1:0] re_ext, im_ext;
  logic signed [2*CW-1:0] re_sq, im_sq;
  logic [SW-1:0]        sum;
  logic [EW-1:0]        shifted;
  logic                 too_big;
  logic [out_width-1:0] mag_sat;

  assign trigger   = sdft_ready && !sdft_ready_d;
  assign busy      = (state != IDLE);
  assign mag_valid = (state == EMIT);
  assign accept    = mag_valid && mag_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: one bin per READ/WAIT/CALC/EMIT pass, EMIT held until accepted
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (trigger) state_nxt = READ;
      READ:    state_nxt = WAIT;
      WAIT:    state_nxt = CALC;
      CALC:    state_nxt = EMIT;
      EMIT:    if (accept) state_nxt = mag_last ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Squared magnitude; operands sign-extended first so -2^(CW-1) squares exactly
  always_comb begin
    re_ext  = {{CW{re_q[CW-1]}}, re_q};
    im_ext  = {{CW{im_q[CW-1]}}, im_q};
    re_sq   = re_ext * re_ext;
    im_sq   = im_ext * im_ext;
    sum     = SW'($unsigned(re_sq)) + SW'($unsigned(im_sq));
    shifted = EW'(sum) >> mag_shift;
    too_big = (shifted >> out_width) != '0;
    mag_sat = too_big ? '1 : shifted[out_width-1:0];
  end

  // Edge detect, overrun flag, read address, operand capture and output beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdft_ready_d <= 1'b0;
      overrun      <= 1'b0;
      bin_addr     <= '0;
      re_q         <= '0;
      im_q         <= '0;
      mag_data     <= '0;
      mag_bin      <= '0;
      mag_last     <= 1'b0;
    end else begin
      sdft_ready_d <= sdft_ready;
      overrun      <= trigger && (state != IDLE);
      case (state)
        IDLE: begin
          if (trigger) bin_addr <= '0;
        end
        WAIT: begin
          re_q <= bin_real;
          im_q <= bin_imag;
        end
        CALC: begin
          mag_data <= mag_sat;
          mag_bin  <= bin_addr;
          mag_last <= (bin_addr == LAST_BIN);
        end
        EMIT: begin
          if (accept) begin
            mag_last <= 1'b0;
            if (!mag_last) bin_addr <= bin_addr + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdft_bin_mag.sv
// tb_sdft_bin_mag: directed plus randomized checks of sdft_bin_mag against a
// scan-level reference model (expected beat queue built at each accepted trigger).
module tb_sdft_bin_mag;

  localparam int DW = 8;
  localparam int FB = 16;
  localparam int SB = 8;
  localparam int MS = 8;
  localparam int OW = 16;
  localparam int AW = $clog2(FB);

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 sdft_ready;
  logic                 mag_ready;
  logic                 busy;
  logic [AW-1:0]        bin_addr;
  logic signed [2*DW-1:0] bin_real, bin_imag;
  logic [OW-1:0]        mag_data;
  logic [AW-1:0]        mag_bin;
  logic                 mag_last, mag_valid, overrun;

  logic signed [2*DW-1:0] re_mem [FB];
  logic signed [2*DW-1:0] im_mem [FB];

  int tests = 0;
  int fails = 0;
  int n_acc = 0;

  sdft_bin_mag #(
    .data_width(DW), .freq_bins(FB), .scan_bins(SB), .mag_shift(MS), .out_width(OW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sdft_ready(sdft_ready), .busy(busy),
    .bin_addr(bin_addr), .bin_real(bin_real), .bin_imag(bin_imag),
    .mag_data(mag_data), .mag_bin(mag_bin), .mag_last(mag_last),
    .mag_valid(mag_valid), .mag_ready(mag_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Bin RAM: one-cycle synchronous read
  always @(posedge clk) begin
    bin_real <= re_mem[bin_addr];
    bin_imag <= im_mem[bin_addr];
  end

  function automatic longint exp_mag(longint re, longint im);
    longint s;
    longint maxv;
    s    = (re * re + im * im) >> MS;
    maxv = (longint'(1) << OW) - 1;
    if (s > maxv) s = maxv;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan-level model: each accepted trigger enqueues the beats of one full scan
  typedef struct {
    int     bin;
    longint mag;
    bit     last;
  } beat_t;

  beat_t q[$];
  beat_t nb;
  bit    m_busy = 1'b0;
  bit    m_prev = 1'b0;
  bit    m_ovr  = 1'b0;
  bit    trig_m, acc_m;

  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      m_busy = 1'b0;
      m_prev = 1'b0;
      m_ovr  = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_valid", mag_valid, 0);
      chk("rst_overrun", overrun, 0);
    end else begin
      chk("busy", busy, m_busy);
      chk("overrun", overrun, m_ovr);
      acc_m = 1'b0;
      if (q.size() == 0) begin
        chk("valid_idle", mag_valid, 0);
      end else if (mag_valid) begin
        chk("mag_data", mag_data, q[0].mag);
        chk("mag_bin", mag_bin, q[0].bin);
        chk("mag_last", mag_last, q[0].last);
        chk("bin_addr", bin_addr, q[0].bin);
        if (mag_ready) begin
          void'(q.pop_front());
          acc_m = 1'b1;
          n_acc++;
        end
      end
      trig_m = sdft_ready && !m_prev;
      m_ovr  = trig_m && m_busy;
      if (trig_m && !m_busy) begin
        for (int b = 0; b < SB; b++) begin
          nb.bin  = b;
          nb.mag  = exp_mag(re_mem[b], im_mem[b]);
          nb.last = (b == SB - 1);
          q.push_back(nb);
        end
        m_busy = 1'b1;
      end else if (acc_m && q.size() == 0) begin
        m_busy = 1'b0;
      end
      m_prev = sdft_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for mag_valid; exp_n < 0 means only the timeout matters
  task automatic wait_valid(input string name, input int exp_n);
    int n;
    n = 0;
    while (n < 40) begin
      step();
      n++;
      if (mag_valid) break;
    end
    if (exp_n >= 0) chk(name, n, exp_n);
    else chk({name, "_timeout"}, mag_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    mag_ready = 1'b1;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk("drain_idle", busy, 0);
  endtask

  task automatic randomize_mem();
    for (int b = 0; b < FB; b++) begin
      case ($urandom_range(0, 5))
        0:       re_mem[b] = 16'sh8000;
        1:       re_mem[b] = 16'sh7fff;
        default: re_mem[b] = 16'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       im_mem[b] = 16'sh8000;
        1:       im_mem[b] = 16'sh7fff;
        default: im_mem[b] = 16'($urandom_range(0, 4095)) - 16'sd2048;
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int base;

    reset_n    = 1'b0;
    sdft_ready = 1'b0;
    mag_ready  = 1'b0;
    randomize_mem();

    // Hand-computed anchors for the reference model
    chk("model_min_sat", exp_mag(-32768, -32768), 65535);
    chk("model_256", exp_mag(256, 0), 256);
    chk("model_4095", exp_mag(4095, 0), 65504);
    chk("model_4096_sat", exp_mag(4096, 0), 65535);
    chk("model_small", exp_mag(-5, 12), 0);

    repeat (3) step();
    chk("rst_bin_addr", bin_addr, 0);
    chk("rst_mag_bin", mag_bin, 0);
    chk("rst_mag_data", mag_data, 0);
    chk("rst_mag_last", mag_last, 0);
    reset_n = 1'b1;
    repeat (2) step();

    // Free-running scan with literal values on the first bins
    re_mem[0] = -16'sd32768; im_mem[0] = -16'sd32768;
    re_mem[1] = 16'sd256;    im_mem[1] = 16'sd0;
    re_mem[2] = 16'sd3;      im_mem[2] = 16'sd4;
    re_mem[3] = -16'sd5;     im_mem[3] = 16'sd12;
    re_mem[4] = 16'sd4095;   im_mem[4] = 16'sd0;
    mag_ready  = 1'b1;
    sdft_ready = 1'b1;
    wait_valid("lat_first", 4);
    chk("b0_bin", mag_bin, 0);
    chk("b0_sat", mag_data, 65535);
    for (int k = 1; k < SB; k++) begin
      wait_valid("bin_period", 4);
      chk("seq_bin", mag_bin, k);
      if (k == 1) chk("b1_val", mag_data, 256);
      if (k == 4) chk("b4_val", mag_data, 65504);
      if (k < SB - 1) chk("not_last", mag_last, 0);
    end
    chk("last_flag", mag_last, 1);
    step();
    chk("busy_fall", busy, 0);

    // Level held high must not retrigger
    seen = 0;
    repeat (50) begin
      step();
      if (mag_valid || busy) seen++;
    end
    chk("no_retrigger", seen, 0);
    sdft_ready = 1'b0;
    step();
    sdft_ready = 1'b1;
    wait_valid("retrig_lat", 4);
    chk("retrig_bin0", mag_bin, 0);
    drain();

    // Backpressure on bin 2
    sdft_ready = 1'b0;
    step();
    sdft_ready = 1'b1;
    mag_ready  = 1'b1;
    wait_valid("bp_b0", -1);
    wait_valid("bp_b1", 4);
    step();
    mag_ready = 1'b0;
    wait_valid("bp_b2", 3);
    chk("bp_b2_bin", mag_bin, 2);
    repeat (4) begin
      step();
      chk("bp_hold_valid", mag_valid, 1);
      chk("bp_hold_bin", mag_bin, 2);
      chk("bp_hold_addr", bin_addr, 2);
    end
    mag_ready = 1'b1;
    wait_valid("bp_b3_lat", 4);
    chk("bp_b3_bin", mag_bin, 3);
    drain();

    // Second rising edge mid-scan
    sdft_ready = 1'b0;
    step();
    base       = n_acc;
    sdft_ready = 1'b1;
    mag_ready  = 1'b1;
    wait_valid("ov_b0", -1);
    wait_valid("ov_b1", -1);
    step();
    sdft_ready = 1'b0;
    step();
    sdft_ready = 1'b1;
    step();
    chk("ovr_pulse", overrun, 1);
    step();
    chk("ovr_clear", overrun, 0);
    drain();
    repeat (20) step();
    chk("ovr_beats", n_acc - base, SB);

    // Final acceptance coinciding with a trigger
    sdft_ready = 1'b0;
    step();
    sdft_ready = 1'b1;
    mag_ready  = 1'b0;
    step();
    sdft_ready = 1'b0;
    for (int k = 0; k < SB - 1; k++) begin
      wait_valid("fa_beat", -1);
      mag_ready = 1'b1;
      step();
      mag_ready = 1'b0;
    end
    wait_valid("fa_last", -1);
    chk("fa_last_bin", mag_bin, SB - 1);
    mag_ready  = 1'b1;
    sdft_ready = 1'b1;
    step();
    chk("fa_busy", busy, 0);
    chk("fa_ovr", overrun, 1);
    chk("fa_valid", mag_valid, 0);
    repeat (20) step();

    // Asynchronous reset while a beat is pending
    sdft_ready = 1'b0;
    step();
    sdft_ready = 1'b1;
    mag_ready  = 1'b0;
    wait_valid("ar_beat", -1);
    #2;
    reset_n    = 1'b0;
    sdft_ready = 1'b0;
    #1;
    chk("arst_valid", mag_valid, 0);
    chk("arst_busy", busy, 0);
    repeat (3) step();
    reset_n   = 1'b1;
    mag_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      step();
      if (mag_valid) seen++;
    end
    chk("arst_quiet", seen, 0);
    sdft_ready = 1'b1;
    wait_valid("arst_new_lat", 4);
    chk("arst_new_bin0", mag_bin, 0);
    drain();

    // Randomized traffic: random data, ready and trigger toggles
    sdft_ready = 1'b0;
    step();
    for (int c = 0; c < 3000; c++) begin
      step();
      mag_ready = ($urandom_range(0, 3) != 0);
      if (!busy && !sdft_ready) randomize_mem();
      if ($urandom_range(0, 24) == 0) sdft_ready = !sdft_ready;
    end
    drain();
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
